fpu_norm_round: RTL and testbench

- Multi-cycle normalize-and-round stage that sits directly downstream of the single-precision add datapath.
- Consumes an unnormalized sum: sign, biased exponent, 25-bit mantissa with carry and hidden bit, and guard/round/sticky bits.
- Produces an IEEE-754 single-precision word using round-to-nearest-even, plus status flags.
- Left normalization is iterative, one bit per cycle, under an FSM. Valid/ready handshakes are used on both sides.

---
 rtl/fpu_norm_round_if.sv | 28 ++
 rtl/fpu_norm_round.sv | 126 ++++++++++++
 tb/tb_fpu_norm_round.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_norm_round_if.sv
// Handshake bundle between the adder datapath, the normalize/round stage
// and its consumer.
interface fpu_norm_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_frac;
    logic [2:0]  in_grs;
    logic        in_bypass;
    logic [31:0] in_bypass_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_frac, in_grs,
        output in_bypass, in_bypass_val, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, in_grs,
        input  in_bypass, in_bypass_val, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_norm_round.sv
// Iterative normalize-and-round stage for the single-precision adder:
// one left shift per cycle, round-to-nearest-even, overflow/underflow flags.
module fpu_norm_round #(
    parameter int BIAS_MAX = 255
) (
    input logic               clk,
    input logic               rst,
    fpu_norm_round_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]  state;
    logic        sign;
    logic [8:0]  exp;
    logic [24:0] frac;
    logic        g;
    logic        r;
    logic        s;
    logic [31:0] result;
    logic [3:0]  flags;

    logic        inc;
    logic        inexact;
    logic [24:0] rsum;
    logic [24:0] rfrac;
    logic [8:0]  rexp;
    logic        ovf;

    assign bus.in_ready   = (state == S_IDLE);
    assign bus.out_valid  = (state == S_OUT);
    assign bus.out_result = result;
    assign bus.out_flags  = flags;

    // Rounding increment may carry into bit24; renormalize once if so.
    always_comb begin
        inc     = g & (r | s | frac[0]);
        inexact = g | r | s;
        rsum    = frac + {24'd0, inc};
        rfrac   = rsum;
        rexp    = exp;
        if (rsum[24]) begin
            rfrac = rsum >> 1;
            rexp  = exp + 9'd1;
        end
        ovf = (rexp >= 9'(BIAS_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sign   <= 1'b0;
            exp    <= 9'd0;
            frac   <= 25'd0;
            g      <= 1'b0;
            r      <= 1'b0;
            s      <= 1'b0;
            result <= 32'd0;
            flags  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sign      <= bus.in_sign;
                        exp       <= {1'b0, bus.in_exp};
                        frac      <= bus.in_frac;
                        {g, r, s} <= bus.in_grs;
                        if (bus.in_bypass) begin
                            result <= bus.in_bypass_val;
                            flags  <= 4'b0000;
                            state  <= S_OUT;
                        end else if (bus.in_frac == 25'd0 &&
                                     bus.in_grs == 3'd0) begin
                            result <= {bus.in_sign, 31'd0};
                            flags  <= 4'b0001;
                            state  <= S_OUT;
                        end else if (bus.in_frac[24]) begin
                            frac  <= {1'b0, bus.in_frac[24:1]};
                            g     <= bus.in_frac[0];
                            r     <= bus.in_grs[2];
                            s     <= bus.in_grs[1] | bus.in_grs[0];
                            exp   <= {1'b0, bus.in_exp} + 9'd1;
                            state <= S_ROUND;
                        end else begin
                            state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (frac[23]) begin
                        state <= S_ROUND;
                    end else if (exp <= 9'd1) begin
                        result <= {sign, 31'd0};
                        flags  <= 4'b0111;
                        state  <= S_OUT;
                    end else begin
                        frac <= {frac[23:0], g};
                        g    <= r;
                        r    <= 1'b0;
                        exp  <= exp - 9'd1;
                    end
                end
                S_ROUND: begin
                    if (ovf) begin
                        result <= {sign, 8'hFF, 23'd0};
                        flags  <= 4'b1010;
                    end else begin
                        result <= {sign, rexp[7:0], rfrac[22:0]};
                        flags  <= {2'b00, inexact, 1'b0};
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed-vector bench for fpu_norm_round: values, flags, latency,
// output hold under back-pressure and mid-operation reset.
module tb_fpu_norm_round;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fpu_norm_round_if bus ();

    fpu_norm_round #(.BIAS_MAX(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] frac;
        logic [2:0]  grs;
        logic        bypass;
        logic [31:0] bval;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic run_op(input vec_t v, input int hold, input string tag);
        int cyc;
        logic [31:0] held;
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_sign       = v.sign;
        bus.in_exp        = v.exp;
        bus.in_frac       = v.frac;
        bus.in_grs        = v.grs;
        bus.in_bypass     = v.bypass;
        bus.in_bypass_val = v.bval;
        bus.in_valid      = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(v.lat));
        chk({tag, " result"}, bus.out_result, v.res);
        chk({tag, " flags"}, 32'(bus.out_flags), 32'(v.flg));
        chk({tag, " busy"}, 32'(bus.in_ready), 32'd0);
        held = bus.out_result;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_frac  = 25'h0400000;
            bus.in_exp   = 8'd10;
            @(posedge clk);
            #1;
            chk({tag, " hold result"}, bus.out_result, held);
            chk({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, " drop valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " idle ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    function automatic vec_t mk(input logic sg, input logic [7:0] e,
                                input logic [24:0] f, input logic [2:0] grs,
                                input logic [31:0] res, input logic [3:0] flg,
                                input int lat);
        vec_t v;
        v.sign   = sg;
        v.exp    = e;
        v.frac   = f;
        v.grs    = grs;
        v.bypass = 1'b0;
        v.bval   = 32'd0;
        v.res    = res;
        v.flg    = flg;
        v.lat    = lat;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        vecs[0]  = mk(0, 127, 25'h1000000, 3'b000, 32'h40000000, 4'b0000, 2);
        vecs[1]  = mk(0, 127, 25'h0200000, 3'b000, 32'h3E800000, 4'b0000, 5);
        vecs[2]  = mk(0, 127, 25'h0800001, 3'b100, 32'h3F800002, 4'b0010, 3);
        vecs[3]  = mk(0, 127, 25'h0800000, 3'b100, 32'h3F800000, 4'b0010, 3);
        vecs[4]  = mk(0, 254, 25'h1FFFFFE, 3'b000, 32'h7F800000, 4'b1010, 2);
        vecs[5]  = mk(1, 254, 25'h1FFFFFE, 3'b000, 32'hFF800000, 4'b1010, 2);
        vecs[6]  = mk(1, 2,   25'h0100000, 3'b000, 32'h80000000, 4'b0111, 3);
        vecs[7]  = mk(0, 127, 25'h0000000, 3'b000, 32'h00000000, 4'b0001, 1);
        vecs[8]  = mk(0, 127, 25'h0FFFFFF, 3'b110, 32'h40000000, 4'b0010, 3);
        vecs[9]  = mk(0, 127, 25'h1000001, 3'b000, 32'h40000000, 4'b0010, 2);
        vecs[10] = mk(0, 127, 25'h0000001, 3'b000, 32'h34000000, 4'b0000, 26);
        vecs[11] = mk(0, 127, 25'h0400000, 3'b100, 32'h3F000001, 4'b0000, 4);
        vecs[12] = mk(0, 1,   25'h0000000, 3'b000, 32'h7FC00000, 4'b0000, 1);
        vecs[12].bypass = 1'b1;
        vecs[12].bval   = 32'h7FC00000;

        bus.in_valid      = 1'b0;
        bus.in_sign       = 1'b0;
        bus.in_exp        = 8'd0;
        bus.in_frac       = 25'd0;
        bus.in_grs        = 3'd0;
        bus.in_bypass     = 1'b0;
        bus.in_bypass_val = 32'd0;
        bus.out_ready     = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset result", bus.out_result, 32'd0);
        chk("reset flags", 32'(bus.out_flags), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // Back-pressure with competing in_valid traffic, then a clean op.
        run_op(vecs[2], 10, "hold");
        run_op(vecs[1], 0, "after_hold");

        // Reset while normalizing a long shift sequence.
        v = vecs[10];
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_frac  = v.frac;
        bus.in_grs   = v.grs;
        bus.in_bypass = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid busy", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) chk("mid rst no output", 32'(bus.out_valid), 32'd0);
        end
        run_op(vecs[0], 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
